// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state encoding and 7-segment constants for the quiz buzzer
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ANSWER  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Digits 1..9; anything else shows blank
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - one button: multi-flop synchroniser followed by rising-edge detect
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pad through the synchroniser chain and remember the last synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/quiz_buzzer_ctrl.sv
// rtl/quiz_buzzer_ctrl.sv - first-presser lock, answer timer and display for N quiz buttons
// Optional false-start lockout selected by FALSE_START_LOCKOUT_EN.
module quiz_buzzer_ctrl
  import quiz_pkg::*;
#(
  parameter int N_PLAYERS     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ANSWER_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic                         clear,
  input  logic [N_PLAYERS-1:0]         btn,
  output logic                         winner_valid,
  output logic [$clog2(N_PLAYERS)-1:0] winner_id,
  output logic                         timeout,
  output logic                         busy,
  output logic [6:0]                   seg
);

  localparam int ID_W    = $clog2(N_PLAYERS);
  localparam int TIMER_W = $clog2(ANSWER_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ANSWER_CYCLES - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [N_PLAYERS-1:0] rise;
  logic [N_PLAYERS-1:0] eligible;
  logic [N_PLAYERS-1:0] cand;
  logic                 hit;
  logic [ID_W-1:0]      hit_idx;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_btn
    btn_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .rise (rise[i])
    );
  end

`ifdef FALSE_START_LOCKOUT_EN
  logic [N_PLAYERS-1:0] penalty;

  // Remember who jumped the gun while idle; forget it once the round is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      penalty <= '0;
    end else if (clear) begin
      penalty <= '0;
    end else if (state == ARMED && !arm) begin
      penalty <= '0;
    end else if (state == IDLE) begin
      penalty <= penalty | rise;
    end
  end

  assign eligible = ~penalty;
`else
  assign eligible = '1;
`endif

  assign cand = rise & eligible;

  // Priority encoder: lowest-numbered eligible edge wins a tie
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
    end
  end

  // Round FSM with answer timer; every output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      seg          <= SEG_BLANK;
      timer        <= '0;
    end else begin
      timeout <= 1'b0;
      if (clear) begin
        state        <= IDLE;
        winner_valid <= 1'b0;
        busy         <= 1'b0;
        seg          <= SEG_BLANK;
        timer        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              busy  <= 1'b1;
              seg   <= SEG_DASH;
            end
          end
          ARMED: begin
            if (!arm) begin
              state <= IDLE;
              busy  <= 1'b0;
              seg   <= SEG_BLANK;
            end else if (hit) begin
              state        <= ANSWER;
              winner_valid <= 1'b1;
              winner_id    <= hit_idx;
              timer        <= TIMER_LOAD;
              seg          <= seg_digit(4'(hit_idx) + 4'd1);
            end
          end
          ANSWER: begin
            if (timer == '0) begin
              state   <= EXPIRED;
              timeout <= 1'b1;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          EXPIRED: begin
            state <= EXPIRED;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quiz_buzzer_ctrl.sv
// tb/tb_quiz_buzzer_ctrl.sv - directed self-checking bench for quiz_buzzer_ctrl
module tb_quiz_buzzer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       clear;
  logic [3:0] btn;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic       timeout;
  logic       busy;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic [6:0] seg_tab [0:3];

  always #5 clk = ~clk;

  quiz_buzzer_ctrl #(
    .N_PLAYERS    (4),
    .SYNC_STAGES  (2),
    .ANSWER_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .clear       (clear),
    .btn         (btn),
    .winner_valid(winner_valid),
    .winner_id   (winner_id),
    .timeout     (timeout),
    .busy        (busy),
    .seg         (seg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Waits (bounded) for a lock, then pops the scoreboard and compares id and digit
  task automatic wait_winner(input string tag);
    bit seen;
    int exp_id;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (winner_valid === 1'b1) seen = 1'b1;
    end
    check({tag, " lock"}, 32'(seen), 32'd1);
    exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check({tag, " id"}, 32'(winner_id), 32'(exp_id));
    check({tag, " seg"}, 32'(seg), 32'(seg_tab[exp_id]));
  endtask

  initial begin
    bit saw_to;
    int k;
    seg_tab[0] = 7'h06;
    seg_tab[1] = 7'h5B;
    seg_tab[2] = 7'h4F;
    seg_tab[3] = 7'h66;
    rst_n = 1'b0;
    arm   = 1'b0;
    clear = 1'b0;
    btn   = 4'b0000;
    #23;
    check("reset wv", 32'(winner_valid), 32'd0);
    check("reset id", 32'(winner_id), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset seg", 32'(seg), 32'h00);
    rst_n = 1'b1;
    tick();

    // 1: single press, exact latency, later presses ignored
    arm = 1'b1;
    tick();
    check("t1 armed seg", 32'(seg), 32'h40);
    check("t1 armed busy", 32'(busy), 32'd1);
    btn = 4'b0100;
    exp_q.push_back(2);
    tick();
    tick();
    check("t1 not yet", 32'(winner_valid), 32'd0);
    tick();
    check("t1 latency", 32'(winner_valid), 32'd1);
    exp_q.pop_front();
    check("t1 id", 32'(winner_id), 32'd2);
    check("t1 seg", 32'(seg), 32'h4F);
    btn = 4'b0101;
    for (int i = 0; i < 4; i++) tick();
    check("t1 late press id", 32'(winner_id), 32'd2);
    check("t1 late press seg", 32'(seg), 32'h4F);
    pulse_clear();
    arm = 1'b0;
    btn = 4'b0000;
    for (int i = 0; i < 4; i++) tick();

    // 2+3: simultaneous presses, then answer window expiry and clear
    arm = 1'b1;
    tick();
    btn = 4'b1010;
    exp_q.push_back(1);
    wait_winner("t2");
    k = 0;
    saw_to = 1'b0;
    while (k < 20 && !saw_to) begin
      tick();
      k++;
      if (timeout === 1'b1) saw_to = 1'b1;
    end
    check("t3 timeout seen", 32'(saw_to), 32'd1);
    check("t3 timeout cycle", 32'(k), 32'd8);
    check("t3 wv held", 32'(winner_valid), 32'd1);
    tick();
    check("t3 timeout pulse", 32'(timeout), 32'd0);
    check("t3 expired wv", 32'(winner_valid), 32'd1);
    check("t3 expired id", 32'(winner_id), 32'd1);
    pulse_clear();
    check("t3 clear wv", 32'(winner_valid), 32'd0);
    check("t3 clear seg", 32'(seg), 32'h00);
    check("t3 clear busy", 32'(busy), 32'd0);
    arm = 1'b0;
    btn = 4'b0000;
    for (int i = 0; i < 4; i++) tick();

    // arm dropping while armed returns to idle
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check("disarm busy", 32'(busy), 32'd0);
    check("disarm seg", 32'(seg), 32'h00);

    // 4: button held across arm gives no edge until re-pressed
    btn = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    pulse_clear();
    arm = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t4 held no winner", 32'(winner_valid), 32'd0);
    btn = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    btn = 4'b0001;
    exp_q.push_back(0);
    wait_winner("t4");

    // 5: asynchronous reset in the middle of the answer window
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async wv", 32'(winner_valid), 32'd0);
    check("t5 async id", 32'(winner_id), 32'd0);
    check("t5 async busy", 32'(busy), 32'd0);
    check("t5 async seg", 32'(seg), 32'h00);
    check("t5 async timeout", 32'(timeout), 32'd0);
    arm = 1'b0;
    btn = 4'b0000;
    #20;
    rst_n = 1'b1;
    saw_to = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout === 1'b1) saw_to = 1'b1;
    end
    check("t5 no spurious timeout", 32'(saw_to), 32'd0);
    check("t5 idle busy", 32'(busy), 32'd0);

    // 6: false start in idle
    btn = 4'b1000;
    for (int i = 0; i < 4; i++) tick();
    btn = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    arm = 1'b1;
    tick();
    btn = 4'b1000;
`ifdef FALSE_START_LOCKOUT_EN
    for (int i = 0; i < 6; i++) tick();
    check("t6 penalised", 32'(winner_valid), 32'd0);
    btn = 4'b0001;
    exp_q.push_back(0);
    wait_winner("t6");
`else
    exp_q.push_back(3);
    wait_winner("t6");
`endif
    pulse_clear();
    check("t6 clear wv", 32'(winner_valid), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
